// File: rtl/oserdes_tx_framer_if.sv
// Payload byte stream into the transmit framer.
// A byte moves on a rising clk edge where s_valid and s_ready are both high;
// the source holds s_data/s_last stable while s_valid is high and not yet accepted.
interface oserdes_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/oserdes_tx_framer.sv
// Word-clock transmit framer for the output serializer: training, idle fill,
// and SOF / byte-stuffed payload / XOR checksum / EOF framing, one word per cycle.
module oserdes_tx_framer #(
    parameter int unsigned TRAIN_WORDS   = 64,
    parameter logic [7:0]  TRAIN_PATTERN = 8'h5C,
    parameter logic [7:0]  IDLE_CODE     = 8'hBC,
    parameter logic [7:0]  SOF_CODE      = 8'hFB,
    parameter logic [7:0]  EOF_CODE      = 8'hFD,
    parameter logic [7:0]  ESC_CODE      = 8'h7D
) (
    input  logic                clk,
    input  logic                rst,
    oserdes_tx_framer_if.slave  s,
    input  logic                retrain,
    output logic [7:0]          d,
    output logic                oce,
    output logic                training,
    output logic [15:0]         frames_sent,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        ST_TRAIN, ST_IDLE, ST_SOF, ST_DATA, ST_ESC2, ST_CHK, ST_CHK2, ST_EOF
    } state_e;

    localparam logic [15:0] TW16    = 16'(TRAIN_WORDS);
    localparam logic [15:0] TW16_M1 = 16'(TRAIN_WORDS - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  esc_q, esc_d;
    logic        esc_last_q, esc_last_d;
    logic [7:0]  d_q, word_d;
    logic        oce_q;
    logic        training_q, training_d;
    logic [15:0] fs_q, fs_d;
    logic        hs;

    function automatic logic is_code(input logic [7:0] b);
        return (b == TRAIN_PATTERN) || (b == IDLE_CODE) || (b == SOF_CODE) ||
               (b == EOF_CODE) || (b == ESC_CODE);
    endfunction

    // A retrain or reset cycle never accepts a byte.
    assign s.s_ready = (state_q == ST_DATA) && !retrain && !rst;
    assign hs        = s.s_ready && s.s_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        esc_d      = esc_q;
        esc_last_d = esc_last_q;
        word_d     = IDLE_CODE;
        training_d = 1'b0;
        fs_d       = fs_q;
        if (retrain) begin
            // The retrain cycle itself emits the first training word.
            word_d     = TRAIN_PATTERN;
            training_d = 1'b1;
            cnt_d      = TW16_M1;
            state_d    = (TRAIN_WORDS == 1) ? ST_IDLE : ST_TRAIN;
        end else begin
            case (state_q)
                ST_TRAIN: begin
                    word_d     = TRAIN_PATTERN;
                    training_d = 1'b1;
                    cnt_d      = cnt_q - 16'd1;
                    if (cnt_q <= 16'd1) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (s.s_valid) state_d = ST_SOF;
                end
                ST_SOF: begin
                    word_d  = SOF_CODE;
                    chk_d   = 8'h00;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (hs) begin
                        chk_d = chk_q ^ s.s_data;
                        if (is_code(s.s_data)) begin
                            word_d     = ESC_CODE;
                            esc_d      = s.s_data ^ 8'h20;
                            esc_last_d = s.s_last;
                            state_d    = ST_ESC2;
                        end else begin
                            word_d = s.s_data;
                            if (s.s_last) state_d = ST_CHK;
                        end
                    end
                end
                ST_ESC2: begin
                    word_d  = esc_q;
                    state_d = esc_last_q ? ST_CHK : ST_DATA;
                end
                ST_CHK: begin
                    if (is_code(chk_q)) begin
                        word_d  = ESC_CODE;
                        state_d = ST_CHK2;
                    end else begin
                        word_d  = chk_q;
                        state_d = ST_EOF;
                    end
                end
                ST_CHK2: begin
                    word_d  = chk_q ^ 8'h20;
                    state_d = ST_EOF;
                end
                ST_EOF: begin
                    word_d  = EOF_CODE;
                    fs_d    = fs_q + 16'd1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_TRAIN;
            cnt_q      <= TW16;
            chk_q      <= 8'h00;
            esc_q      <= 8'h00;
            esc_last_q <= 1'b0;
            d_q        <= 8'h00;
            oce_q      <= 1'b0;
            training_q <= 1'b1;
            fs_q       <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            esc_q      <= esc_d;
            esc_last_q <= esc_last_d;
            d_q        <= word_d;
            oce_q      <= 1'b1;
            training_q <= training_d;
            fs_q       <= fs_d;
        end
    end

    assign d           = d_q;
    assign oce         = oce_q;
    assign training    = training_q;
    assign frames_sent = fs_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_oserdes_tx_framer.sv
// Bench for oserdes_tx_framer: word-queue reference model, directed frames
// pinned by literal word sequences, then randomized frames with retrain pulses.
module tb_oserdes_tx_framer;
    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retrain = 1'b0;
    logic [7:0]  d;
    logic        oce;
    logic        training;
    logic [15:0] frames_sent;
    logic [2:0]  dbg_state;

    oserdes_tx_framer_if sif ();

    oserdes_tx_framer #(.TRAIN_WORDS(TW)) dut (
        .clk(clk), .rst(rst), .s(sif), .retrain(retrain), .d(d), .oce(oce),
        .training(training), .frames_sent(frames_sent), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: words still owed to the line, plus frame/training bookkeeping.
    logic [7:0]  owed[$];
    logic [7:0]  mdl_log[$];
    logic [25:0] exp_q[$];
    bit          m_acc = 1'b0;
    int          m_train = TW;
    logic [15:0] m_frames = 16'h0;
    logic [7:0]  m_chk = 8'h0;

    // Source side.
    logic [8:0]  src_q[$];
    bit          sv = 1'b0;
    int          gap_cnt = 0;
    bit          gap_once = 1'b0;
    bit          rand_valid = 1'b0;
    bit          retrain_on_esc = 1'b0;
    int          rt_idx = 0;
    int          rst_cnt = 3;
    bit          rst_on_data = 1'b0;
    int          rt_rate = 0;

    function automatic bit is_code(input logic [7:0] b);
        return (b == 8'h5C) || (b == 8'hBC) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'h7D);
    endfunction

    task automatic push_stuffed(input logic [7:0] b);
        if (is_code(b)) begin
            owed.push_back(8'h7D);
            owed.push_back(b ^ 8'h20);
        end else begin
            owed.push_back(b);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cycle();
        logic [25:0] e;
        logic [7:0]  w;
        bit          rdy;
        bit          etr;
        bit          eoce;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("d", {24'h0, d}, {24'h0, e[25:18]});
            check("oce", {31'h0, oce}, {31'h0, e[17]});
            check("training", {31'h0, training}, {31'h0, e[16]});
            check("frames_sent", {16'h0, frames_sent}, {16'h0, e[15:0]});
        end
        // drive this cycle's inputs
        if (rst_on_data && m_acc) begin
            rst_cnt = 2;
            rst_on_data = 1'b0;
        end
        rst = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;
        retrain = 1'b0;
        if (retrain_on_esc && m_acc && owed.size() > 0) begin
            retrain = 1'b1;
            retrain_on_esc = 1'b0;
            rt_idx = mdl_log.size();
        end else if (rt_rate > 0 && $urandom_range(1, rt_rate) == 1) begin
            retrain = 1'b1;
        end
        if (!sv && src_q.size() > 0) begin
            if (gap_cnt > 0) gap_cnt--;
            else if (!rand_valid || $urandom_range(0, 3) != 0) sv = 1'b1;
        end
        sif.s_valid = sv;
        sif.s_data  = sv ? src_q[0][7:0] : 8'($urandom);
        sif.s_last  = sv ? src_q[0][8] : 1'($urandom_range(0, 1));
        #1;
        // model step
        if (rst) begin
            owed.delete();
            m_acc = 1'b0; m_train = TW; m_frames = 16'h0; m_chk = 8'h0;
            rdy = 1'b0; w = 8'h00; etr = 1'b1; eoce = 1'b0;
        end else begin
            eoce = 1'b1;
            rdy = m_acc && owed.size() == 0 && !retrain;
            if (retrain) begin
                owed.delete();
                m_acc = 1'b0;
                m_train = TW;
            end
            if (m_train > 0) begin
                w = 8'h5C; m_train--; etr = 1'b1;
            end else begin
                etr = 1'b0;
                if (m_acc && owed.size() == 0) begin
                    if (sv) begin
                        m_chk ^= sif.s_data;
                        push_stuffed(sif.s_data);
                        if (sif.s_last) begin
                            m_acc = 1'b0;
                            push_stuffed(m_chk);
                            owed.push_back(8'hFD);
                        end
                        w = owed.pop_front();
                    end else begin
                        w = 8'hBC;
                    end
                end else if (owed.size() > 0) begin
                    w = owed.pop_front();
                    if (w == 8'hFB) begin
                        m_acc = 1'b1;
                        m_chk = 8'h0;
                    end else if (w == 8'hFD) begin
                        m_frames++;
                    end
                end else begin
                    w = 8'hBC;
                    if (sv) owed.push_back(8'hFB);
                end
            end
        end
        check("s_ready", {31'h0, sif.s_ready}, {31'h0, rdy});
        if (rdy && sv) begin
            void'(src_q.pop_front());
            sv = 1'b0;
            if (gap_once) begin
                gap_cnt = 2;
                gap_once = 1'b0;
            end
        end
        exp_q.push_back({w, eoce, etr, m_frames});
        mdl_log.push_back(w);
    endtask

    task automatic push_frame(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++)
            src_q.push_back({(i == n - 1), bytes[63 - 8 * i -: 8]});
    endtask

    task automatic wait_frames(input logic [15:0] target);
        int k = 0;
        while (m_frames != target && k < 3000) begin
            run_cycle();
            k++;
        end
        check("frame_wait", {16'h0, m_frames}, {16'h0, target});
    endtask

    task automatic check_tail(input string name, input logic [63:0] words, input int n);
        logic [63:0] act = '0;
        for (int i = 0; i < n; i++)
            act[63 - 8 * i -: 8] = mdl_log[mdl_log.size() - n + i];
        check(name, act[63:32], words[63:32]);
        check(name, act[31:0], words[31:0]);
    endtask

    initial begin
        logic [7:0] codes[5];
        int k;
        int len;
        codes = '{8'h5C, 8'hBC, 8'hFB, 8'hFD, 8'h7D};
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        sif.s_last  = 1'b0;

        repeat (10) run_cycle();
        check_tail("train_seq", 64'h005C5C5C5CBCBCBC, 8);

        push_frame(64'h010203_0000000000, 3);
        wait_frames(16'd1);
        check_tail("frame_010203", 64'hBCFB01020300FD00, 7);
        repeat (2) run_cycle();

        push_frame(64'hFB11_000000000000, 2);
        wait_frames(16'd2);
        check_tail("frame_fb11", 64'hFB7DDB11EAFD0000, 6);

        push_frame(64'h5CE1_000000000000, 2);
        wait_frames(16'd3);
        check_tail("frame_5ce1", 64'hFB7D7CE1BDFD0000, 6);
        push_frame(64'h7DC0_000000000000, 2);
        wait_frames(16'd4);
        check_tail("frame_7dc0", 64'hFB7D5DC0BDFD0000, 6);
        push_frame(64'hAA17_000000000000, 2);
        wait_frames(16'd5);
        check_tail("frame_aa17", 64'hFBAA17BDFD000000, 5);
        push_frame(64'hFD00_000000000000, 1);
        wait_frames(16'd6);
        check_tail("frame_fd_chk", 64'hFB7DDD7DDDFD0000, 6);
        repeat (2) run_cycle();

        gap_once = 1'b1;
        push_frame(64'h0102_000000000000, 2);
        wait_frames(16'd7);
        check_tail("underrun", 64'hFB01BCBC0203FD00, 7);
        repeat (2) run_cycle();

        retrain_on_esc = 1'b1;
        push_frame(64'hFB11_000000000000, 2);
        wait_frames(16'd8);
        check("pre_retrain_word", {24'h0, mdl_log[rt_idx - 1]}, 32'h7D);
        check("retrain_word", {24'h0, mdl_log[rt_idx]}, 32'h5C);
        check_tail("after_retrain", 64'h5C5C5CBCFB1111FD, 8);
        repeat (2) run_cycle();

        rst_on_data = 1'b1;
        push_frame(64'h101112131415_0000, 6);
        k = 0;
        while ((rst_on_data || rst_cnt > 0) && k < 200) begin
            run_cycle();
            k++;
        end
        check("frames_after_rst", {16'h0, m_frames}, 32'h0);
        wait_frames(16'd1);

        rand_valid = 1'b1;
        rt_rate = 300;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 4)] : 8'($urandom);
                src_q.push_back({(i == len - 1), b});
            end
        end
        k = 0;
        while ((src_q.size() > 0 || sv || m_acc || owed.size() > 0) && k < 20000) begin
            run_cycle();
            k++;
        end
        check("drain_done", src_q.size(), 32'h0);
        rt_rate = 0;
        repeat (8) run_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
